ext_mem_arbiter: RTL and testbench

Shares the single-port-pair external memory (one read port, one write port, 1-cycle registered read) between two read clients and two write clients. Each client requests a burst with a base address and length. The arbiter grants round-robin, generates incrementing addresses, and streams data to or from the client. The read and write paths are independent and run concurrently. The block sits between the external memory and the layer loader / write-back engines.

---
 rtl/ext_mem_arbiter.sv | 137 +++++++++++++
 tb/tb_ext_mem_arbiter.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/ext_mem_arbiter.sv
// ext_mem_arbiter: round-robin burst arbiter sharing one external memory read port and one write port
// between two read clients and two write clients.
module emarb_chan #(
    parameter int ADDR_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req,
    input  logic [ADDR_W-1:0] addr_0,
    input  logic [ADDR_W-1:0] addr_1,
    input  logic [LEN_W-1:0]  len_0,
    input  logic [LEN_W-1:0]  len_1,
    output logic [1:0]        gnt,
    output logic              busy,
    output logic              own,
    output logic              last,
    output logic [ADDR_W-1:0] cur_addr
);
    typedef enum logic {IDLE, BURST} state_t;
    state_t state, state_nx;
    logic ptr, sel;
    logic [LEN_W-1:0] cnt;
    assign sel  = (&req) ? ptr : req[1];
    assign busy = state == BURST;
    assign last = busy && cnt == '0;
    always_comb begin
        gnt      = '0;
        state_nx = state;
        if (state == IDLE) begin
            if (|req && !rst) begin
                gnt[sel] = 1'b1;
                state_nx = BURST;
            end
        end else if (cnt == '0) begin
            state_nx = IDLE;
        end
    end
    always_ff @(posedge clk) state <= rst ? IDLE : state_nx;
    // cur_addr stops on the last beat so it doubles as the held idle address
    always_ff @(posedge clk) begin
        if (rst) begin
            ptr      <= 1'b0;
            own      <= 1'b0;
            cnt      <= '0;
            cur_addr <= '0;
        end else if (|gnt) begin
            own      <= sel;
            ptr      <= ~sel;
            cur_addr <= sel ? addr_1 : addr_0;
            cnt      <= sel ? len_1 : len_0;
        end else if (busy && cnt != '0) begin
            cur_addr <= cur_addr + 1'b1;
            cnt      <= cnt - 1'b1;
        end
    end
endmodule

module ext_mem_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16,
    parameter int LEN_W  = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req_0,
    input  logic              rd_req_1,
    input  logic [ADDR_W-1:0] rd_addr_0,
    input  logic [ADDR_W-1:0] rd_addr_1,
    input  logic [LEN_W-1:0]  rd_len_0,
    input  logic [LEN_W-1:0]  rd_len_1,
    output logic              rd_gnt_0,
    output logic              rd_gnt_1,
    output logic              rd_vld_0,
    output logic              rd_vld_1,
    output logic              rd_done_0,
    output logic              rd_done_1,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req_0,
    input  logic              wr_req_1,
    input  logic [ADDR_W-1:0] wr_addr_0,
    input  logic [ADDR_W-1:0] wr_addr_1,
    input  logic [LEN_W-1:0]  wr_len_0,
    input  logic [LEN_W-1:0]  wr_len_1,
    input  logic [DATA_W-1:0] wr_data_0,
    input  logic [DATA_W-1:0] wr_data_1,
    output logic              wr_gnt_0,
    output logic              wr_gnt_1,
    output logic              wr_rdy_0,
    output logic              wr_rdy_1,
    output logic              wr_done_0,
    output logic              wr_done_1,
    output logic              mem_re,
    output logic [ADDR_W-1:0] mem_rd_addr,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_wr_addr,
    output logic [DATA_W-1:0] mem_data_in,
    input  logic [DATA_W-1:0] mem_data_out
);
    logic r_own, r_last, w_busy, w_own, w_last;
    logic vld_q, own_q, last_q;
    emarb_chan #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_rd (
        .clk, .rst, .req({rd_req_1, rd_req_0}),
        .addr_0(rd_addr_0), .addr_1(rd_addr_1), .len_0(rd_len_0), .len_1(rd_len_1),
        .gnt({rd_gnt_1, rd_gnt_0}), .busy(mem_re), .own(r_own), .last(r_last),
        .cur_addr(mem_rd_addr)
    );
    emarb_chan #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_wr (
        .clk, .rst, .req({wr_req_1, wr_req_0}),
        .addr_0(wr_addr_0), .addr_1(wr_addr_1), .len_0(wr_len_0), .len_1(wr_len_1),
        .gnt({wr_gnt_1, wr_gnt_0}), .busy(w_busy), .own(w_own), .last(w_last),
        .cur_addr(mem_wr_addr)
    );
    // tracks the memory's one-cycle read latency
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= 1'b0;
            own_q  <= 1'b0;
            last_q <= 1'b0;
        end else begin
            vld_q  <= mem_re;
            own_q  <= r_own;
            last_q <= r_last;
        end
    end
    assign rd_vld_0    = vld_q & ~own_q;
    assign rd_vld_1    = vld_q & own_q;
    assign rd_done_0   = rd_vld_0 & last_q;
    assign rd_done_1   = rd_vld_1 & last_q;
    assign rd_data     = mem_data_out;
    assign mem_we      = w_busy;
    assign wr_rdy_0    = w_busy & ~w_own;
    assign wr_rdy_1    = w_busy & w_own;
    assign wr_done_0   = wr_rdy_0 & w_last;
    assign wr_done_1   = wr_rdy_1 & w_last;
    assign mem_data_in = !w_busy ? '0 : w_own ? wr_data_1 : wr_data_0;
endmodule

// File: tb/tb_ext_mem_arbiter.sv
// tb_ext_mem_arbiter: scoreboard bench for ext_mem_arbiter with a behavioural 1-cycle memory.
module tb_ext_mem_arbiter;
    logic        clk = 0, rst = 1;
    logic        rd_req_0 = 0, rd_req_1 = 0;
    logic [15:0] rd_addr_0 = 0, rd_addr_1 = 0;
    logic [7:0]  rd_len_0 = 0, rd_len_1 = 0;
    logic        rd_gnt_0, rd_gnt_1, rd_vld_0, rd_vld_1, rd_done_0, rd_done_1;
    logic [15:0] rd_data;
    logic        wr_req_0 = 0, wr_req_1 = 0;
    logic [15:0] wr_addr_0 = 0, wr_addr_1 = 0;
    logic [7:0]  wr_len_0 = 0, wr_len_1 = 0;
    logic [15:0] wr_data_0 = 0, wr_data_1 = 0;
    logic        wr_gnt_0, wr_gnt_1, wr_rdy_0, wr_rdy_1, wr_done_0, wr_done_1;
    logic        mem_re, mem_we;
    logic [15:0] mem_rd_addr, mem_wr_addr, mem_data_in, mem_data_out;
    logic        pl_we = 0;
    logic [15:0] pl_addr = 0, pl_data = 0;
    logic [15:0] mem [0:65535];
    int tests = 0, fails = 0, ov = 0;

    typedef struct {logic c; logic [15:0] d; logic dn;} rexp_t;
    typedef struct {logic c; logic [15:0] a; logic [15:0] d; logic dn;} wexp_t;
    logic        gq[$];
    logic [15:0] aq[$];
    rexp_t       rq[$];
    wexp_t       wq[$];

    ext_mem_arbiter dut (
        .clk(clk), .rst(rst),
        .rd_req_0(rd_req_0), .rd_req_1(rd_req_1), .rd_addr_0(rd_addr_0), .rd_addr_1(rd_addr_1),
        .rd_len_0(rd_len_0), .rd_len_1(rd_len_1), .rd_gnt_0(rd_gnt_0), .rd_gnt_1(rd_gnt_1),
        .rd_vld_0(rd_vld_0), .rd_vld_1(rd_vld_1), .rd_done_0(rd_done_0), .rd_done_1(rd_done_1),
        .rd_data(rd_data),
        .wr_req_0(wr_req_0), .wr_req_1(wr_req_1), .wr_addr_0(wr_addr_0), .wr_addr_1(wr_addr_1),
        .wr_len_0(wr_len_0), .wr_len_1(wr_len_1), .wr_data_0(wr_data_0), .wr_data_1(wr_data_1),
        .wr_gnt_0(wr_gnt_0), .wr_gnt_1(wr_gnt_1), .wr_rdy_0(wr_rdy_0), .wr_rdy_1(wr_rdy_1),
        .wr_done_0(wr_done_0), .wr_done_1(wr_done_1),
        .mem_re(mem_re), .mem_rd_addr(mem_rd_addr), .mem_we(mem_we), .mem_wr_addr(mem_wr_addr),
        .mem_data_in(mem_data_in), .mem_data_out(mem_data_out)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (pl_we) mem[pl_addr] <= pl_data;
        else if (mem_we) mem[mem_wr_addr] <= mem_data_in;
        if (mem_re) mem_data_out <= mem[mem_rd_addr];
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // monitor: pops an expectation for every DUT event
    always @(negedge clk) begin
        if (rd_gnt_0 | rd_gnt_1) begin
            if (gq.size() == 0) chk("rd_gnt_unexp", {rd_gnt_1, rd_gnt_0}, 0);
            else begin
                automatic logic g = gq.pop_front();
                chk("rd_gnt_client", {rd_gnt_1, rd_gnt_0}, g ? 2 : 1);
            end
        end
        if (mem_re) begin
            if (aq.size() == 0) chk("mem_re_unexp", mem_re, 0);
            else chk("mem_rd_addr", mem_rd_addr, aq.pop_front());
        end
        if (rd_vld_0 | rd_vld_1) begin
            if (rq.size() == 0) chk("rd_vld_unexp", {rd_vld_1, rd_vld_0}, 0);
            else begin
                automatic rexp_t e = rq.pop_front();
                chk("rd_vld_client", {rd_vld_1, rd_vld_0}, e.c ? 2 : 1);
                chk("rd_data", rd_data, e.d);
                chk("rd_done", {rd_done_1, rd_done_0}, e.dn ? (e.c ? 2 : 1) : 0);
            end
        end
        if (mem_we) begin
            if (wq.size() == 0) chk("mem_we_unexp", mem_we, 0);
            else begin
                automatic wexp_t e = wq.pop_front();
                chk("wr_rdy_client", {wr_rdy_1, wr_rdy_0}, e.c ? 2 : 1);
                chk("mem_wr_addr", mem_wr_addr, e.a);
                chk("mem_data_in", mem_data_in, e.d);
                chk("wr_done", {wr_done_1, wr_done_0}, e.dn ? (e.c ? 2 : 1) : 0);
            end
        end
        if (mem_re && mem_we) ov++;
    end

    task automatic preload(input logic [15:0] a, input logic [15:0] d);
        pl_we = 1; pl_addr = a; pl_data = d;
        @(posedge clk); #1;
        pl_we = 0;
    endtask

    task automatic rd(input logic k, input logic [15:0] a, input logic [7:0] l);
        logic got = 0;
        if (k) begin rd_req_1 = 1; rd_addr_1 = a; rd_len_1 = l; end
        else   begin rd_req_0 = 1; rd_addr_0 = a; rd_len_0 = l; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = k ? rd_gnt_1 : rd_gnt_0;
        end
        chk("rd_gnt_seen", got, 1);
        @(posedge clk); #1;
        if (k) rd_req_1 = 0; else rd_req_0 = 0;
        repeat (int'(l) + 3) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic k, input logic [15:0] a, input logic [7:0] l, input logic [63:0] dv);
        logic got = 0;
        if (k) begin wr_req_1 = 1; wr_addr_1 = a; wr_len_1 = l; end
        else   begin wr_req_0 = 1; wr_addr_0 = a; wr_len_0 = l; end
        for (int i = 0; i < 20 && !got; i++) begin
            @(negedge clk);
            got = k ? wr_gnt_1 : wr_gnt_0;
        end
        chk("wr_gnt_seen", got, 1);
        for (int i = 0; i <= int'(l); i++) begin
            @(posedge clk); #1;
            if (k) begin wr_req_1 = 0; wr_data_1 = dv[16*i +: 16]; end
            else   begin wr_req_0 = 0; wr_data_0 = dv[16*i +: 16]; end
        end
        @(posedge clk); #1;
        wr_data_0 = 0; wr_data_1 = 0;
    endtask

    initial begin
        int ng;
        preload(16'h0010, 16'hA0A0); preload(16'h0011, 16'hB0B1);
        preload(16'h0012, 16'hC0C2); preload(16'h0013, 16'hD0D3);
        preload(16'h0020, 16'h2020); preload(16'h0030, 16'h3030);
        preload(16'h0040, 16'h4444); preload(16'hFFFE, 16'h5A5A);
        preload(16'hFFFF, 16'hA5A5);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("rst_rd_gnt", {rd_gnt_1, rd_gnt_0}, 0);
        chk("rst_rd_vld", {rd_vld_1, rd_vld_0}, 0);
        chk("rst_mem_re", mem_re, 0);
        chk("rst_mem_we", mem_we, 0);
        chk("rst_rd_addr", mem_rd_addr, 0);
        chk("rst_wr_addr", mem_wr_addr, 0);
        chk("rst_data_in", mem_data_in, 0);
        chk("rst_wr_rdy", {wr_rdy_1, wr_rdy_0}, 0);

        // contention straight from reset: grants alternate starting with client 0
        for (int i = 0; i < 2; i++) begin
            gq.push_back(0); aq.push_back(16'h0020); rq.push_back('{0, 16'h2020, 1});
            gq.push_back(1); aq.push_back(16'h0030); rq.push_back('{1, 16'h3030, 1});
        end
        @(posedge clk); #1;
        rd_addr_0 = 16'h0020; rd_addr_1 = 16'h0030; rd_len_0 = 0; rd_len_1 = 0;
        rd_req_0 = 1; rd_req_1 = 1;
        ng = 0;
        for (int i = 0; i < 30 && ng < 4; i++) begin
            @(negedge clk);
            if (rd_gnt_0 | rd_gnt_1) ng++;
        end
        chk("contention_grants", ng, 4);
        @(posedge clk); #1;
        rd_req_0 = 0; rd_req_1 = 0;
        repeat (4) @(posedge clk);
        #1;

        // single 4-beat read
        gq.push_back(0);
        for (int i = 0; i < 4; i++) aq.push_back(16'h0010 + 16'(i));
        rq.push_back('{0, 16'hA0A0, 0}); rq.push_back('{0, 16'hB0B1, 0});
        rq.push_back('{0, 16'hC0C2, 0}); rq.push_back('{0, 16'hD0D3, 1});
        rd(0, 16'h0010, 3);

        // write then read back
        wq.push_back('{1, 16'h0100, 16'h1234, 0}); wq.push_back('{1, 16'h0101, 16'hBEEF, 1});
        wr(1, 16'h0100, 1, 64'h0000_0000_BEEF_1234);
        gq.push_back(0); aq.push_back(16'h0100); aq.push_back(16'h0101);
        rq.push_back('{0, 16'h1234, 0}); rq.push_back('{0, 16'hBEEF, 1});
        rd(0, 16'h0100, 1);

        // address wrap with a concurrent write feeding the wrapped read addresses
        gq.push_back(0);
        aq.push_back(16'hFFFE); aq.push_back(16'hFFFF); aq.push_back(16'h0000); aq.push_back(16'h0001);
        rq.push_back('{0, 16'h5A5A, 0}); rq.push_back('{0, 16'hA5A5, 0});
        rq.push_back('{0, 16'h1111, 0}); rq.push_back('{0, 16'h2222, 1});
        wq.push_back('{0, 16'h0000, 16'h1111, 0}); wq.push_back('{0, 16'h0001, 16'h2222, 0});
        wq.push_back('{0, 16'h0002, 16'h3333, 0}); wq.push_back('{0, 16'h0003, 16'h4444, 1});
        ov = 0;
        fork
            rd(0, 16'hFFFE, 3);
            wr(0, 16'h0000, 3, 64'h4444_3333_2222_1111);
        join
        chk("re_we_overlap", ov, 4);
        chk("rd_addr_held", mem_rd_addr, 16'h0001);
        chk("data_in_idle", mem_data_in, 0);

        // reset during the second beat of an 8-beat read
        gq.push_back(0); aq.push_back(16'h0040); aq.push_back(16'h0041);
        rq.push_back('{0, 16'h4444, 0});
        rd_req_0 = 1; rd_addr_0 = 16'h0040; rd_len_0 = 7;
        ng = 0;
        for (int i = 0; i < 20 && ng == 0; i++) begin
            @(negedge clk);
            if (rd_gnt_0) ng = 1;
        end
        chk("rst_test_gnt", ng, 1);
        @(posedge clk); #1;
        rd_req_0 = 0;
        @(posedge clk); #1;
        rst = 1;
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        chk("post_rst_mem_re", mem_re, 0);
        chk("post_rst_vld", {rd_vld_1, rd_vld_0}, 0);
        repeat (10) @(posedge clk);
        #1;
        gq.push_back(1); aq.push_back(16'h0030); rq.push_back('{1, 16'h3030, 1});
        rd(1, 16'h0030, 0);

        repeat (4) @(posedge clk);
        chk("gq_empty", gq.size(), 0);
        chk("aq_empty", aq.size(), 0);
        chk("rq_empty", rq.size(), 0);
        chk("wq_empty", wq.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
